uart_hex_reporter: RTL and testbench
====================================

# uart_hex_reporter

Sequencer that sits in front of `uart_tx` and turns one SRAM test result (address + data word) into a fixed-format ASCII line. It converts each nibble to an uppercase hex character, emits the characters one at a time through the `tx_start`/`tx_done_tick` handshake, and reports completion. The SRAM tester uses it to log mismatches and readback values on the host terminal.

## Interface

- `ADDR_W`, 20: address width in bits; multiple of 4, range 4–32; emitted as `ADDR_W/4` hex digits.
- `DATA_W`, 8: data width in bits; multiple of 4, range 4–32; emitted as `DATA_W/4` hex digits.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  1  request to send one report line; sampled only in IDLE.
- `req_addr`  in  ADDR_W  address to print; captured on an accepted `req`.
- `req_data`  in  DATA_W  data to print; captured on an accepted `req`.
- `busy`  out  1  high from the cycle after acceptance until the line is complete.
- `done_tick`  out  1  one-cycle pulse when the last character has finished.
- `tx_start`  out  1  one-cycle pulse to `uart_tx`: start sending `tx_data`.
- `tx_data`  out  8  character to `uart_tx`; registered.
- `tx_ready`  in  1  `uart_tx` is idle and can accept `tx_start`.
- `tx_done_tick`  in  1  `uart_tx` stop bit has finished.

## Operation

- Line format: address hex digits (MSB nibble first), `:` (0x3A), data hex digits (MSB first), CR (0x0D), LF (0x0A).
- Line length: N = ADDR_W/4 + DATA_W/4 + 3 bytes. With the default parameters, N = 10.
- Nibble encoding: n in 0–9 maps to 0x30+n; n in 10–15 maps to 0x37+n (uppercase A–F).
- Byte index counter: width is ceil(log2(N)), counting 0 to N−1.
- On acceptance, `req_addr` and `req_data` are captured into internal registers. Later changes on the inputs have no effect on the line in progress.
- FSM states:
  - IDLE: `busy`=0. If `req`=1, capture the inputs, set index to 0, load `tx_data` with byte 0, and go to ISSUE.
  - ISSUE: `busy`=1. `tx_start` = `tx_ready` (combinational, Moore-gated by the state). When `tx_ready`=1, go to WAIT.
  - WAIT: `busy`=1. Ignore `tx_ready`. On `tx_done_tick`:
    - If index = N−1, go to IDLE and assert `done_tick` in the next cycle.
    - Otherwise, increment the index, load `tx_data` with the next byte, and go to ISSUE.
- `tx_data` changes only on a transition into ISSUE. It is held stable through ISSUE and WAIT.
- `tx_done_tick` is ignored in IDLE and ISSUE. `req` is ignored outside IDLE: no queuing, no capture.
- Reset at any time:
  - Next cycle the block is in IDLE with index 0.
  - No further `tx_start` is issued; the partial line is abandoned.
  - The next `req` sends a full line starting from byte 0.

## Timing

- Reset values: `busy`=0, `done_tick`=0, `tx_start`=0, `tx_data`=0x00, state IDLE, index 0.
- `req` sampled high in cycle 0:
  - Cycle 1: `busy`=1 and `tx_data` = byte 0.
  - If `tx_ready`=1, `tx_start`=1 in cycle 1.
- `tx_start` is exactly one cycle wide per byte, even if `tx_ready` stays high.
- Exactly N `tx_start` pulses are issued per accepted `req`.
- After a `tx_done_tick` in cycle t, ISSUE holds from cycle t+1. `tx_start` is asserted at the first cycle ≥ t+1 with `tx_ready`=1. `uart_tx` returns to idle at t+1, so the gap between bytes is 1 cycle.
- Final `tx_done_tick` in cycle t: in cycle t+1, `done_tick`=1 and `busy`=0, with the state in IDLE.
- A `req` in the `done_tick` cycle is accepted, so back-to-back lines have no extra gap.
- Simultaneous `reset` and `req`: reset wins and the `req` is dropped.

## Test plan

- Default parameters, `req_addr`=0x1A2B3, `req_data`=0xC4, with a real `uart_tx` + baud tick:
  - `tx_data` sequence is 31 41 32 42 33 3A 43 34 0D 0A.
  - 10 `tx_start` pulses, 1 `done_tick`; `busy` is high throughout and drops together with `done_tick`.
- Digit boundaries: addr 0x00000 / data 0x00 gives "00000:00\r\n". Addr 0xFFFFF / data 0xFF gives 46×5, 3A, 46 46, 0D 0A. Addr 0x09A9A gives 30 39 41 39 41 (covers the 9/A boundary).
- `req` pulsed mid-line with addr 0x11111 / data 0x22, and input values changed after acceptance: the line of the originally captured values completes unchanged, exactly 10 bytes, with no second line.
- Stubbed `uart_tx`:
  - `tx_ready` held low for 20 cycles in ISSUE: no `tx_start` and `tx_data` stable; a single pulse follows when `tx_ready` rises.
  - `tx_ready` held high: `tx_start` is still one cycle wide.
- `reset` asserted during WAIT of byte 4:
  - Next cycle `busy`=0, `tx_start`=0, `tx_data`=0x00, and no `done_tick`.
  - A subsequent `req` (addr 0x00001, data 0x5A) produces the full "00001:5A\r\n".
- `req` held high continuously for two lines: the second line starts in the `done_tick` cycle. `done_tick` pulses twice and 20 bytes are sent in total.

Source files
------------

// File: rtl/uart_hex_reporter.sv
// Turns one captured (address, data) pair into an ASCII line "AAAAA:DD\r\n" and feeds it
// byte by byte to a uart_tx through the tx_start / tx_done_tick handshake.
module uart_hex_reporter #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              busy,
  output logic              done_tick,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  input  logic              tx_done_tick
);

  localparam int ADDR_DIG = ADDR_W / 4;
  localparam int DATA_DIG = DATA_W / 4;
  localparam int N_BYTES  = ADDR_DIG + DATA_DIG + 3;
  localparam int IDX_W    = $clog2(N_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                done_tick_q, done_tick_d;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  // Byte at position idx of the line: address digits, ':', data digits, CR, LF.
  function automatic logic [7:0] line_byte(input logic [IDX_W-1:0] idx,
                                           input logic [ADDR_W-1:0] a,
                                           input logic [DATA_W-1:0] d);
    int         pos;
    logic [7:0] ch;
    pos = int'(idx);
    if (pos < ADDR_DIG)
      ch = hex_char(4'(a >> (4 * (ADDR_DIG - 1 - pos))));
    else if (pos == ADDR_DIG)
      ch = 8'h3A;
    else if (pos <= ADDR_DIG + DATA_DIG)
      ch = hex_char(4'(d >> (4 * (ADDR_DIG + DATA_DIG - pos))));
    else if (pos == N_BYTES - 2)
      ch = 8'h0D;
    else
      ch = 8'h0A;
    return ch;
  endfunction

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    data_d      = data_q;
    tx_data_d   = tx_data_q;
    done_tick_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d    = req_addr;
          data_d    = req_data;
          idx_d     = '0;
          tx_data_d = line_byte('0, req_addr, req_data);
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (tx_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done_tick) begin
          if (idx_q == LAST_IDX) begin
            state_d     = S_IDLE;
            done_tick_d = 1'b1;
          end else begin
            idx_d     = idx_q + IDX_W'(1);
            tx_data_d = line_byte(idx_q + IDX_W'(1), addr_q, data_q);
            state_d   = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      tx_data_q   <= 8'h00;
      done_tick_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tx_data_q   <= tx_data_d;
      done_tick_q <= done_tick_d;
    end
  end

  // Captured operands only matter while a line is in flight, so they carry no reset.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  assign busy      = (state_q != S_IDLE);
  assign tx_start  = (state_q == S_ISSUE) && tx_ready;
  assign tx_data   = tx_data_q;
  assign done_tick = done_tick_q;

endmodule

// File: tb/tb_uart_hex_reporter.sv
// Bench for uart_hex_reporter: a stub uart_tx, a queue-based line model checked every cycle,
// and directed lines with literal byte expectations.
module tb_uart_hex_reporter;

  localparam int ADDR_W  = 20;
  localparam int DATA_W  = 8;
  localparam int N_BYTES = ADDR_W / 4 + DATA_W / 4 + 3;
  localparam int BIT_CYC = 12;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_data = '0;
  logic              busy, done_tick, tx_start;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic              tx_done_tick = 1'b0;

  always #5 clk = ~clk;

  uart_hex_reporter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
    .busy(busy), .done_tick(done_tick), .tx_start(tx_start), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx_done_tick(tx_done_tick)
  );

  // Stub uart_tx: busy for BIT_CYC+1 cycles per byte, then a one-cycle done tick.
  int   ready_mode = 0;  // 0 = follows stub, 1 = forced low, 2 = forced high
  logic u_busy = 1'b0;
  int   u_cnt = 0;
  assign tx_ready = (ready_mode == 2) ? 1'b1 : (ready_mode == 1) ? 1'b0 : !u_busy;

  always @(posedge clk) begin
    tx_done_tick <= 1'b0;
    if (tx_start) begin
      u_busy <= 1'b1;
      u_cnt  <= BIT_CYC;
    end else if (u_busy) begin
      if (u_cnt == 0) begin
        u_busy       <= 1'b0;
        tx_done_tick <= 1'b1;
      end else begin
        u_cnt <= u_cnt - 1;
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Line model: expected bytes kept as a queue built from a hex-digit lookup string.
  string      hex_s = "0123456789ABCDEF";
  logic [7:0] exp_q[$];
  logic [7:0] sent_q[$];
  bit         m_active = 0, m_pending = 0, m_done = 0;
  int         m_sent = 0;
  int         start_cnt = 0, done_cnt = 0;
  bit         cmp_en = 0;

  function automatic void push_line(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    for (int k = ADDR_W / 4 - 1; k >= 0; k--) exp_q.push_back(8'(hex_s[int'((a >> (4 * k)) & 'hF)]));
    exp_q.push_back(8'h3A);
    for (int k = DATA_W / 4 - 1; k >= 0; k--) exp_q.push_back(8'(hex_s[int'((d >> (4 * k)) & 'hF)]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", {31'b0, busy}, {31'b0, m_active});
      chk("done_tick", {31'b0, done_tick}, {31'b0, m_done});
      chk("tx_start", {31'b0, tx_start}, {31'b0, m_active && m_pending && tx_ready});
      if (m_active && m_pending && exp_q.size() > 0) chk("tx_data", {24'b0, tx_data}, {24'b0, exp_q[0]});
    end
    if (tx_start === 1'b1) begin
      sent_q.push_back(tx_data);
      start_cnt++;
    end
    if (done_tick === 1'b1) done_cnt++;
    if (reset) begin
      m_active = 0; m_pending = 0; m_done = 0; m_sent = 0;
      exp_q.delete();
    end else begin
      m_done = 0;
      if (!m_active) begin
        if (req) begin
          m_active = 1; m_pending = 1; m_sent = 0;
          exp_q.delete();
          push_line(req_addr, req_data);
        end
      end else if (m_pending) begin
        if (tx_ready) begin
          m_pending = 0;
          m_sent++;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end else if (tx_done_tick) begin
        if (m_sent == N_BYTES) begin
          m_active = 0;
          m_done   = 1;
        end else begin
          m_pending = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_addr = a;
    req_data = d;
    req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  task automatic wait_done(input string name, input int base);
    for (int c = 0; c < 3000 && done_cnt == base; c++) tick();
    chk({name, " finished"}, {31'b0, done_cnt != base}, 32'd1);
  endtask

  task automatic check_line(input string name, input logic [7:0] e[10], input int off);
    for (int i = 0; i < 10; i++)
      chk($sformatf("%s[%0d]", name, i),
          (off + i < sent_q.size()) ? {24'b0, sent_q[off + i]} : 32'hDEAD, {24'b0, e[i]});
  endtask

  task automatic run_line(input string name, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [7:0] e[10]);
    int s0, d0;
    sent_q.delete();
    s0 = start_cnt;
    d0 = done_cnt;
    send_req(a, d);
    wait_done(name, d0);
    repeat (5) tick();
    check_line(name, e, 0);
    chk({name, " starts"}, 32'(start_cnt - s0), 32'd10);
    chk({name, " dones"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e[10];
    int s0, d0, ndone;

    repeat (3) tick();
    reset = 1'b0;
    cmp_en = 1'b1;
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst done_tick", {31'b0, done_tick}, 32'd0);
    chk("rst tx_start", {31'b0, tx_start}, 32'd0);
    chk("rst tx_data", {24'b0, tx_data}, 32'h00);
    tick();

    e = '{8'h31, 8'h41, 8'h32, 8'h42, 8'h33, 8'h3A, 8'h43, 8'h34, 8'h0D, 8'h0A};
    run_line("line_1A2B3", 20'h1A2B3, 8'hC4, e);
    e = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h3A, 8'h30, 8'h30, 8'h0D, 8'h0A};
    run_line("line_zero", 20'h00000, 8'h00, e);
    e = '{8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h3A, 8'h46, 8'h46, 8'h0D, 8'h0A};
    run_line("line_ones", 20'hFFFFF, 8'hFF, e);
    e = '{8'h30, 8'h39, 8'h41, 8'h39, 8'h41, 8'h3A, 8'h39, 8'h41, 8'h0D, 8'h0A};
    run_line("line_9A", 20'h09A9A, 8'h9A, e);

    // req pulsed mid-line with new operands must not disturb the captured line
    sent_q.delete();
    s0 = start_cnt; d0 = done_cnt;
    send_req(20'h11111, 8'h22);
    for (int c = 0; c < 500 && start_cnt - s0 < 3; c++) tick();
    req_addr = 20'hFEDCB; req_data = 8'hEE; req = 1'b1;
    tick();
    req = 1'b0; req_addr = 20'h55555;
    wait_done("midreq", d0);
    repeat (40) tick();
    e = '{8'h31, 8'h31, 8'h31, 8'h31, 8'h31, 8'h3A, 8'h32, 8'h32, 8'h0D, 8'h0A};
    check_line("midreq", e, 0);
    chk("midreq starts", 32'(start_cnt - s0), 32'd10);
    chk("midreq dones", 32'(done_cnt - d0), 32'd1);

    // tx_ready held low in ISSUE
    sent_q.delete();
    s0 = start_cnt; d0 = done_cnt;
    ready_mode = 1;
    send_req(20'h7ABCD, 8'h12);
    for (int c = 0; c < 20; c++) begin
      chk("hold tx_start", {31'b0, tx_start}, 32'd0);
      chk("hold tx_data", {24'b0, tx_data}, 32'h37);
      tick();
    end
    ready_mode = 0;
    #1;
    chk("release tx_start", {31'b0, tx_start}, 32'd1);
    wait_done("hold", d0);
    e = '{8'h37, 8'h41, 8'h42, 8'h43, 8'h44, 8'h3A, 8'h31, 8'h32, 8'h0D, 8'h0A};
    check_line("hold", e, 0);
    chk("hold starts", 32'(start_cnt - s0), 32'd10);

    // tx_ready held high: pulses must still be single-cycle
    ready_mode = 2;
    e = '{8'h30, 8'h30, 8'h41, 8'h42, 8'h43, 8'h3A, 8'h33, 8'h43, 8'h0D, 8'h0A};
    run_line("rdy_high", 20'h00ABC, 8'h3C, e);
    ready_mode = 0;

    // reset during WAIT of byte 4
    sent_q.delete();
    s0 = start_cnt; d0 = done_cnt;
    send_req(20'h12345, 8'h67);
    for (int c = 0; c < 1000 && start_cnt - s0 < 5; c++) tick();
    chk("pre-reset starts", 32'(start_cnt - s0), 32'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort busy", {31'b0, busy}, 32'd0);
    chk("abort tx_start", {31'b0, tx_start}, 32'd0);
    chk("abort tx_data", {24'b0, tx_data}, 32'h00);
    chk("abort done_tick", {31'b0, done_tick}, 32'd0);
    repeat (30) tick();
    chk("abort no more starts", 32'(start_cnt - s0), 32'd5);
    chk("abort no done", 32'(done_cnt - d0), 32'd0);
    e = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h31, 8'h3A, 8'h35, 8'h41, 8'h0D, 8'h0A};
    run_line("after_reset", 20'h00001, 8'h5A, e);

    // reset and req together: reset wins
    s0 = start_cnt;
    req_addr = 20'hABCDE; req_data = 8'h11; req = 1'b1; reset = 1'b1;
    tick();
    req = 1'b0; reset = 1'b0;
    chk("rst+req busy", {31'b0, busy}, 32'd0);
    repeat (5) tick();
    chk("rst+req starts", 32'(start_cnt - s0), 32'd0);

    // req held high for two back-to-back lines
    sent_q.delete();
    s0 = start_cnt; d0 = done_cnt; ndone = 0;
    req_addr = 20'h00ABC; req_data = 8'h3C; req = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (done_tick) begin
        ndone++;
        if (ndone == 2) begin
          req = 1'b0;
          break;
        end
        tick();
        chk("b2b restart busy", {31'b0, busy}, 32'd1);
      end
    end
    req = 1'b0;
    chk("b2b two dones", 32'(ndone), 32'd2);
    repeat (40) tick();
    e = '{8'h30, 8'h30, 8'h41, 8'h42, 8'h43, 8'h3A, 8'h33, 8'h43, 8'h0D, 8'h0A};
    check_line("b2b line1", e, 0);
    check_line("b2b line2", e, 10);
    chk("b2b starts", 32'(start_cnt - s0), 32'd20);
    chk("b2b dones", 32'(done_cnt - d0), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
